regfile_mp: RTL

Parametrised multi-port register file with an integrated debug-bus agent. It serves the core with one write port and `READ_PORTS` synchronous read ports. It answers debug-bus read/write commands addressed to `DEBUG_ADDR`, and core writes always take priority over debug writes. It replaces the fixed 16x32 single-port register file in the core datapath.

---
 rtl/regfile_mp.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file: one core write port, READ_PORTS registered read ports and a debug-bus agent.
// Define REGFILE_BYPASS_EN to forward same-edge writes to the read ports.
module regfile_mp #(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH      = 16,
    parameter int          READ_PORTS = 2,
    parameter logic [7:0]  DEBUG_ADDR = 8'd1,
    localparam int         AW         = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [READ_PORTS*AW-1:0]      rd_addr,
    output logic [READ_PORTS*WIDTH-1:0]   rd_data,
    input  logic                          wr_en,
    input  logic [AW-1:0]                 wr_addr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [7:0]                    debug_bus_addr,
    input  logic                          debug_bus_start,
    inout  wire  [63:0]                   debug_bus_data,
    output wire                           debug_bus_available,
    output wire                           debug_bus_accepted
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t              state;
    logic                accepted;
    logic                available;
    logic [63:0]         resp;
    logic [63:0]         cmd;
    logic [WIDTH-1:0]    mem [DEPTH];

    logic                sel;
    logic                cmd_wr;
    logic [7:0]          cmd_idx;
    logic [WIDTH-1:0]    cmd_data;
    logic                cmd_ok;
    logic [AW-1:0]       dbg_idx;
    logic                core_we;
    logic                dbg_we;
    logic                unused_cmd;

    assign sel      = (debug_bus_addr == DEBUG_ADDR);
    assign cmd_wr   = cmd[0];
    assign cmd_idx  = cmd[8:1];
    assign cmd_data = cmd[WIDTH+31:32];
    assign cmd_ok   = int'(cmd_idx) < DEPTH;
    assign dbg_idx  = cmd_idx[AW-1:0];
    assign core_we  = wr_en && (int'(wr_addr) < DEPTH);
    // A pending debug write yields to any core write strobe, even an out-of-range one.
    assign dbg_we   = (state == EXEC) && cmd_wr && !wr_en && cmd_ok;
    assign unused_cmd = ^{cmd[63:32], cmd[31:9]};

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (core_we) mem[wr_addr] <= wr_data;
            if (dbg_we)  mem[dbg_idx] <= cmd_data;
        end
    end

    logic [WIDTH-1:0] rd_next [READ_PORTS];

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign rd_next[p] = (int'(a) >= DEPTH)            ? '0       :
                            (core_we && wr_addr == a)     ? wr_data  :
                            (dbg_we && dbg_idx == a)      ? cmd_data :
                                                            mem[a];
`else
        assign rd_next[p] = (int'(a) >= DEPTH) ? '0 : mem[a];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < READ_PORTS; p++) rd_data[p*WIDTH +: WIDTH] <= rd_next[p];
        end
    end

    // RESP spans two cycles: the first lines up the response, the second raises available.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            accepted  <= 1'b0;
            available <= 1'b0;
            resp      <= '0;
            cmd       <= '0;
        end else begin
            accepted <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel && debug_bus_start) begin
                        cmd      <= debug_bus_data;
                        accepted <= 1'b1;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!(cmd_wr && wr_en)) begin
                        if (!cmd_ok)     resp <= '1;
                        else if (cmd_wr) resp <= 64'h1;
                        else             resp <= {{(64-WIDTH){1'b0}}, mem[dbg_idx]};
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (!available) begin
                        available <= 1'b1;
                    end else begin
                        available <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign debug_bus_data      = (sel && state == RESP) ? resp : 64'bz;
    assign debug_bus_accepted  = sel ? accepted  : 1'bz;
    assign debug_bus_available = sel ? available : 1'bz;

endmodule
